// File: rtl/tl_tx_write_splitter_pkg.sv
// Shared TL_TX write-path definitions: MPS encodings, page/request limits, FSM states.
// Pure definitions, no logic; MPS encodings match the RX checker.
package tl_tx_write_splitter_pkg;

  localparam logic [2:0] MPS_128B  = 3'b010;
  localparam logic [2:0] MPS_256B  = 3'b011;
  localparam logic [2:0] MPS_512B  = 3'b100;
  localparam logic [2:0] MPS_1024B = 3'b101;

  localparam int PAGE_DW    = 1024;
  localparam int MAX_REQ_DW = 4096;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  // Unknown or reserved encodings fall back to the smallest legal payload.
  function automatic logic [10:0] mps_decode(input logic [2:0] cfg);
    case (cfg)
      MPS_128B:  return 11'd128;
      MPS_256B:  return 11'd256;
      MPS_512B:  return 11'd512;
      MPS_1024B: return 11'd1024;
      default:   return 11'd32;
    endcase
  endfunction

endpackage

// File: rtl/tl_tx_write_splitter_seg_len_calc.sv
// Segment length = min(remaining, MPS, room left in the 4 KB page); flags the final segment.
// Purely combinational, no latency, no flow control.
module tl_tx_seg_len_calc
  import tl_tx_write_splitter_pkg::*;
#(
  parameter int REQ_LEN_WIDTH = 13
) (
  input  logic [REQ_LEN_WIDTH-1:0] remaining,
  input  logic [10:0]              mps_dw,
  input  logic [9:0]               page_off,
  output logic [10:0]              seg,
  output logic                     hdr_last
);

  logic [10:0]              page_room;
  logic [10:0]              cap;
  logic [REQ_LEN_WIDTH-1:0] cap_ext;
  logic [REQ_LEN_WIDTH-1:0] seg_ext;

  // page_room is 1..1024, so it never reaches zero
  assign page_room = 11'(PAGE_DW) - {1'b0, page_off};
  assign cap       = (mps_dw < page_room) ? mps_dw : page_room;
  assign cap_ext   = {{(REQ_LEN_WIDTH-11){1'b0}}, cap};
  assign seg       = (remaining < cap_ext) ? remaining[10:0] : cap;
  assign seg_ext   = {{(REQ_LEN_WIDTH-11){1'b0}}, seg};
  assign hdr_last  = (remaining == seg_ext);

endmodule

// File: rtl/tl_tx_write_splitter.sv
// Splits one write request into MWr header descriptors bounded by MPS and 4 KB pages.
// First header one cycle after acceptance, one per cycle; hdr_ready low holds all hdr_* stable.
module tl_tx_write_splitter
  import tl_tx_write_splitter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int REQ_LEN_WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [2:0]               max_payload_config,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [REQ_LEN_WIDTH-1:0] req_len,
  output logic                     req_err,
  output logic                     hdr_valid,
  input  logic                     hdr_ready,
  output logic [ADDR_WIDTH-1:0]    hdr_addr,
  output logic [9:0]               hdr_len,
  output logic                     hdr_fmt_4dw,
  output logic [3:0]               hdr_first_be,
  output logic [3:0]               hdr_last_be,
  output logic [2:0]               hdr_tc,
  output logic [1:0]               hdr_attr,
  output logic [1:0]               hdr_at,
  output logic                     hdr_last
);

  localparam logic [REQ_LEN_WIDTH-1:0] MAX_LEN = MAX_REQ_DW[REQ_LEN_WIDTH-1:0];

  state_t                   state, state_nxt;
  logic [ADDR_WIDTH-3:0]    cur_addr;
  logic [REQ_LEN_WIDTH-1:0] remaining;
  logic [10:0]              mps_dw;
  logic                     req_err_q;
  logic [10:0]              seg;
  logic                     seg_last;
  logic                     len_bad;
  logic                     accept;
  logic                     unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];
  assign len_bad = (req_len == '0) || (req_len > MAX_LEN);
  assign accept  = req_valid && req_ready;

  tl_tx_seg_len_calc #(.REQ_LEN_WIDTH(REQ_LEN_WIDTH)) u_seg_len_calc (
    .remaining (remaining),
    .mps_dw    (mps_dw),
    .page_off  (cur_addr[9:0]),
    .seg       (seg),
    .hdr_last  (seg_last)
  );

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    hdr_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !len_bad) state_nxt = ST_SPLIT;
      end
      ST_SPLIT: begin
        hdr_valid = 1'b1;
        if (hdr_ready && seg_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      mps_dw    <= 11'd32;
      req_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_err_q <= accept && len_bad;
      if (accept && !len_bad) begin
        cur_addr  <= req_addr[ADDR_WIDTH-1:2];
        remaining <= req_len;
        mps_dw    <= mps_decode(max_payload_config);
      end else if (hdr_valid && hdr_ready) begin
        // carry runs through the full address, so a 4 GB crossing flips to 4DW
        cur_addr  <= cur_addr + {{(ADDR_WIDTH-13){1'b0}}, seg};
        remaining <= remaining - {{(REQ_LEN_WIDTH-11){1'b0}}, seg};
      end
    end
  end

  assign req_err      = req_err_q;
  assign hdr_addr     = hdr_valid ? {cur_addr, 2'b00} : '0;
  assign hdr_len      = hdr_valid ? seg[9:0] : 10'd0;
  assign hdr_last     = hdr_valid && seg_last;
  assign hdr_fmt_4dw  = |hdr_addr[ADDR_WIDTH-1:32];
  assign hdr_first_be = 4'hF;
  assign hdr_last_be  = (seg == 11'd1) ? 4'h0 : 4'hF;
  assign hdr_tc       = 3'd0;
  assign hdr_attr     = 2'd0;
  assign hdr_at       = 2'd0;

endmodule

// File: tb/tb_tl_tx_write_splitter.sv
// Directed bench for tl_tx_write_splitter; inputs change and outputs are sampled on the falling edge.
module tb_tl_tx_write_splitter;

  logic        clk = 1'b0;
  logic        arst;
  logic [2:0]  max_payload_config;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [12:0] req_len;
  logic        req_err;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [63:0] hdr_addr;
  logic [9:0]  hdr_len;
  logic        hdr_fmt_4dw;
  logic [3:0]  hdr_first_be;
  logic [3:0]  hdr_last_be;
  logic [2:0]  hdr_tc;
  logic [1:0]  hdr_attr;
  logic [1:0]  hdr_at;
  logic        hdr_last;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tl_tx_write_splitter dut (
    .clk                (clk),
    .arst               (arst),
    .max_payload_config (max_payload_config),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           (req_addr),
    .req_len            (req_len),
    .req_err            (req_err),
    .hdr_valid          (hdr_valid),
    .hdr_ready          (hdr_ready),
    .hdr_addr           (hdr_addr),
    .hdr_len            (hdr_len),
    .hdr_fmt_4dw        (hdr_fmt_4dw),
    .hdr_first_be       (hdr_first_be),
    .hdr_last_be        (hdr_last_be),
    .hdr_tc             (hdr_tc),
    .hdr_attr           (hdr_attr),
    .hdr_at             (hdr_at),
    .hdr_last           (hdr_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; returns on the edge where the first header is visible.
  task automatic send(input logic [63:0] addr, input logic [12:0] len, input logic [2:0] mps);
    req_valid          = 1'b1;
    req_addr           = addr;
    req_len            = len;
    max_payload_config = mps;
    chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Checks the header currently presented, then advances one cycle.
  task automatic expect_hdr(input string tag, input logic [63:0] addr, input logic [9:0] len,
                            input logic last);
    chk({tag, "_valid"}, {63'd0, hdr_valid}, 64'd1);
    chk({tag, "_addr"}, hdr_addr, addr);
    chk({tag, "_len"}, {54'd0, hdr_len}, {54'd0, len});
    chk({tag, "_last"}, {63'd0, hdr_last}, {63'd0, last});
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    chk({tag, "_hdr_valid"}, {63'd0, hdr_valid}, 64'd0);
  endtask

  initial begin
    arst               = 1'b1;
    req_valid          = 1'b0;
    req_addr           = '0;
    req_len            = '0;
    max_payload_config = 3'b010;
    hdr_ready          = 1'b1;

    // reset state
    #12;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_hdr_valid", {63'd0, hdr_valid}, 64'd0);
    chk("rst_req_err", {63'd0, req_err}, 64'd0);
    chk("rst_hdr_last", {63'd0, hdr_last}, 64'd0);
    chk("rst_hdr_addr", hdr_addr, 64'd0);
    chk("rst_hdr_len", {54'd0, hdr_len}, 64'd0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    // 300 DW at 0x1000, MPS 128
    send(64'h1000, 13'd300, 3'b010);
    chk("t1_first_be", {60'd0, hdr_first_be}, 64'hF);
    chk("t1_tc_attr_at", {57'd0, hdr_tc, hdr_attr, hdr_at}, 64'd0);
    chk("t1_fmt", {63'd0, hdr_fmt_4dw}, 64'd0);
    expect_hdr("t1_s0", 64'h1000, 10'd128, 1'b0);
    expect_hdr("t1_s1", 64'h1200, 10'd128, 1'b0);
    chk("t1_s2_last_be", {60'd0, hdr_last_be}, 64'hF);
    expect_hdr("t1_s2", 64'h1400, 10'd44, 1'b1);
    expect_idle("t1_done");
    @(negedge clk);

    // 4 KB crossing
    send(64'h0FF0, 13'd10, 3'b101);
    expect_hdr("t2_s0", 64'h0FF0, 10'd4, 1'b0);
    expect_hdr("t2_s1", 64'h1000, 10'd6, 1'b1);
    expect_idle("t2_done");

    // full 1024 DW above 4 GB
    send(64'h1_0000_0000, 13'd1024, 3'b101);
    chk("t3_fmt", {63'd0, hdr_fmt_4dw}, 64'd1);
    chk("t3_last_be", {60'd0, hdr_last_be}, 64'hF);
    expect_hdr("t3_s0", 64'h1_0000_0000, 10'd0, 1'b1);
    expect_idle("t3_done");

    // illegal lengths
    send(64'h2000, 13'd0, 3'b010);
    chk("t4_err_len0", {63'd0, req_err}, 64'd1);
    chk("t4_no_hdr_len0", {63'd0, hdr_valid}, 64'd0);
    @(negedge clk);
    chk("t4_err_pulse_len0", {63'd0, req_err}, 64'd0);
    chk("t4_no_hdr_len0_b", {63'd0, hdr_valid}, 64'd0);
    send(64'h2000, 13'd4097, 3'b010);
    chk("t4_err_len4097", {63'd0, req_err}, 64'd1);
    chk("t4_no_hdr_len4097", {63'd0, hdr_valid}, 64'd0);
    @(negedge clk);
    chk("t4_err_pulse_len4097", {63'd0, req_err}, 64'd0);

    // single DW
    send(64'h2003, 13'd1, 3'b010);
    chk("t5_last_be", {60'd0, hdr_last_be}, 64'h0);
    expect_hdr("t5_s0", 64'h2000, 10'd1, 1'b1);
    expect_idle("t5_done");

    // reserved MPS encoding -> 32 DW
    send(64'h0, 13'd40, 3'b111);
    expect_hdr("t6_s0", 64'h0, 10'd32, 1'b0);
    expect_hdr("t6_s1", 64'h80, 10'd8, 1'b1);
    expect_idle("t6_done");

    // backpressure with MPS changed after acceptance
    hdr_ready = 1'b0;
    send(64'h3000, 13'd200, 3'b010);
    max_payload_config = 3'b000;
    for (int i = 0; i < 5; i++) begin
      chk("t7_hold_valid", {63'd0, hdr_valid}, 64'd1);
      chk("t7_hold_addr", hdr_addr, 64'h3000);
      chk("t7_hold_len", {54'd0, hdr_len}, 64'd128);
      chk("t7_hold_last", {63'd0, hdr_last}, 64'd0);
      @(negedge clk);
    end
    hdr_ready = 1'b1;
    expect_hdr("t7_s0", 64'h3000, 10'd128, 1'b0);
    expect_hdr("t7_s1", 64'h3200, 10'd72, 1'b1);
    expect_idle("t7_done");

    // reset during the second of three segments
    send(64'h4000, 13'd384, 3'b010);
    expect_hdr("t8_s0", 64'h4000, 10'd128, 1'b0);
    chk("t8_s1_addr", hdr_addr, 64'h4200);
    arst = 1'b1;
    #1;
    chk("t8_rst_hdr_valid", {63'd0, hdr_valid}, 64'd0);
    chk("t8_rst_req_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    send(64'h5000, 13'd2, 3'b010);
    expect_hdr("t8_new", 64'h5000, 10'd2, 1'b1);
    expect_idle("t8_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
